uart_fifo_core: RTL

Parametrised UART core with independent TX and RX FIFOs and 16x-oversampled receive. Data width, FIFO depth and oversampling are compile-time parameters; parity mode and stop-bit count are selected at run time. Framing, parity and overrun errors are detected and reported. The block is the drop-in successor to the fixed-format UART top. It sits between a valid/ready host interface and the `tx_out`/`rx_in` pins.

---
 rtl/uart_fifo_core.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// UART core: TX/RX FIFOs, runtime parity/stop selection, oversampled receiver.
// Frame, parity and overrun errors are reported alongside the RX FIFO head.
module uart_fifo_core #(
    parameter int DATA_LEN   = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          parity_mode,
    input  logic                stop2,
    input  logic                tx_valid,
    input  logic [DATA_LEN-1:0] tx_data,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_out,
    input  logic                rx_in,
    output logic                rx_valid,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
    input  logic                rx_ready,
    output logic                overrun,
    input  logic                clr_overrun
);
    localparam int SAMPLE_HZ = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_RND   = (CLK_FREQ + SAMPLE_HZ / 2) / SAMPLE_HZ;
    localparam int DIV       = (DIV_RND < 1) ? 1 : DIV_RND;
    localparam int BIT_CYC   = DIV * OVERSAMPLE;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(BIT_CYC);
    localparam int BW        = $clog2(DATA_LEN);
    localparam int SW        = $clog2(OVERSAMPLE);
    localparam int DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW        = DATA_LEN + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_LEN-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW:0]         r_tx_wr, r_tx_rd;
    logic                w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_LEN-1:0] w_tx_head;

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[AW] != r_tx_rd[AW]) && (r_tx_wr[AW-1:0] == r_tx_rd[AW-1:0]);
    assign w_tx_push  = tx_valid && !w_tx_full;
    assign w_tx_head  = r_tx_mem[r_tx_rd[AW-1:0]];
    assign tx_ready   = !w_tx_full;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= tx_data;
    end

    // ---------------- TX FSM ----------------
    state_t              r_tx_state, w_tx_state_next;
    logic [CW-1:0]       r_tx_cnt;
    logic [BW-1:0]       r_tx_bit;
    logic [DATA_LEN-1:0] r_tx_shift;
    logic [1:0]          r_tx_mode;
    logic                r_tx_par, r_tx_stop2, r_tx_stop_second, r_tx_out;
    logic                w_tx_tick, w_tx_par_on;

    assign w_tx_tick   = (r_tx_cnt == CW'(BIT_CYC - 1));
    assign w_tx_par_on = r_tx_mode[0] ^ r_tx_mode[1];
    assign tx_busy     = (r_tx_state != S_IDLE) || !w_tx_empty;
    assign tx_out      = r_tx_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= S_IDLE;
        else     r_tx_state <= w_tx_state_next;
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            S_IDLE:   if (!w_tx_empty) begin
                          w_tx_pop        = 1'b1;
                          w_tx_state_next = S_START;
                      end
            S_START:  if (w_tx_tick) w_tx_state_next = S_DATA;
            S_DATA:   if (w_tx_tick && r_tx_bit == BW'(DATA_LEN - 1))
                          w_tx_state_next = w_tx_par_on ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_tick) w_tx_state_next = S_STOP;
            S_STOP:   if (w_tx_tick && (r_tx_stop_second || !r_tx_stop2)) begin
                          // Chain straight into the next start bit when more data waits.
                          if (!w_tx_empty) begin
                              w_tx_pop        = 1'b1;
                              w_tx_state_next = S_START;
                          end else begin
                              w_tx_state_next = S_IDLE;
                          end
                      end
            default:  w_tx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_shift <= '0;
            r_tx_mode <= 2'b00;
            r_tx_par <= 1'b0;
            r_tx_stop2 <= 1'b0;
            r_tx_stop_second <= 1'b0;
            r_tx_out <= 1'b1;
        end else begin
            r_tx_wr  <= r_tx_wr + (AW+1)'(w_tx_push);
            r_tx_rd  <= r_tx_rd + (AW+1)'(w_tx_pop);
            r_tx_cnt <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_pop) begin
                r_tx_shift       <= w_tx_head;
                r_tx_par         <= (^w_tx_head) ^ (parity_mode == 2'b10);
                r_tx_mode        <= parity_mode;
                r_tx_stop2       <= stop2;
                r_tx_stop_second <= 1'b0;
                r_tx_bit         <= '0;
            end else if (w_tx_tick) begin
                if (r_tx_state == S_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 1'b1;
                end
                if (r_tx_state == S_STOP) r_tx_stop_second <= 1'b1;
            end
            case (r_tx_state)
                S_START:  r_tx_out <= 1'b0;
                S_DATA:   r_tx_out <= r_tx_shift[0];
                S_PARITY: r_tx_out <= r_tx_par;
                default:  r_tx_out <= 1'b1;
            endcase
        end
    end

    // ---------------- RX front end and FSM ----------------
    state_t              r_rx_state, w_rx_state_next;
    logic                r_rx_s1, r_rx_s2, r_rx_prev, r_rx_perr;
    logic [DW-1:0]       r_rx_div;
    logic [SW-1:0]       r_rx_cnt;
    logic [BW-1:0]       r_rx_bit;
    logic [DATA_LEN-1:0] r_rx_shift;
    logic [1:0]          r_rx_mode;
    logic                w_rx_fall, w_rx_stick, w_rx_sample, w_rx_push, w_rx_par_on;

    assign w_rx_fall   = r_rx_prev && !r_rx_s2;
    assign w_rx_stick  = (r_rx_div == DW'(DIV - 1));
    assign w_rx_par_on = r_rx_mode[0] ^ r_rx_mode[1];
    assign w_rx_sample = w_rx_stick && ((r_rx_state == S_START) ?
                         (r_rx_cnt == SW'(OVERSAMPLE / 2 - 1)) : (r_rx_cnt == SW'(OVERSAMPLE - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= S_IDLE;
        else     r_rx_state <= w_rx_state_next;
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_push       = 1'b0;
        case (r_rx_state)
            S_IDLE:   if (w_rx_fall) w_rx_state_next = S_START;
            S_START:  if (w_rx_sample) w_rx_state_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_sample && r_rx_bit == BW'(DATA_LEN - 1))
                          w_rx_state_next = w_rx_par_on ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_sample) w_rx_state_next = S_STOP;
            S_STOP:   if (w_rx_sample) begin
                          w_rx_push       = 1'b1;
                          w_rx_state_next = S_IDLE;
                      end
            default:  w_rx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_div <= '0;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_shift <= '0;
            r_rx_mode <= 2'b00;
            r_rx_perr <= 1'b0;
        end else begin
            r_rx_s1   <= rx_in;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (r_rx_state == S_IDLE) begin
                r_rx_div <= '0;
                r_rx_cnt <= '0;
                if (w_rx_fall) begin
                    r_rx_mode <= parity_mode;
                    r_rx_bit  <= '0;
                    r_rx_perr <= 1'b0;
                end
            end else begin
                r_rx_div <= w_rx_stick ? '0 : r_rx_div + 1'b1;
                if (w_rx_stick) r_rx_cnt <= w_rx_sample ? '0 : r_rx_cnt + 1'b1;
                if (w_rx_sample && r_rx_state == S_DATA) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_LEN-1:1]};
                    r_rx_bit   <= r_rx_bit + 1'b1;
                end
                if (w_rx_sample && r_rx_state == S_PARITY)
                    r_rx_perr <= r_rx_s2 != ((^r_rx_shift) ^ (r_rx_mode == 2'b10));
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW:0]   r_rx_wr, r_rx_rd;
    logic          r_overrun;
    logic          w_rx_empty, w_rx_full, w_rx_pop, w_rx_accept;
    logic [EW-1:0] w_rx_head;

    assign w_rx_empty  = (r_rx_wr == r_rx_rd);
    assign w_rx_full   = (r_rx_wr[AW] != r_rx_rd[AW]) && (r_rx_wr[AW-1:0] == r_rx_rd[AW-1:0]);
    assign w_rx_pop    = !w_rx_empty && rx_ready;
    assign w_rx_accept = w_rx_push && (!w_rx_full || w_rx_pop);
    // Empty FIFO presents zeros so the head outputs are defined from reset.
    assign w_rx_head   = w_rx_empty ? '0 : r_rx_mem[r_rx_rd[AW-1:0]];
    assign rx_valid      = !w_rx_empty;
    assign rx_data       = w_rx_head[DATA_LEN-1:0];
    assign rx_parity_err = w_rx_head[DATA_LEN];
    assign rx_frame_err  = w_rx_head[DATA_LEN+1];
    assign overrun       = r_overrun;

    always_ff @(posedge clk) begin
        if (w_rx_accept) r_rx_mem[r_rx_wr[AW-1:0]] <= {!r_rx_s2, r_rx_perr, r_rx_shift};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_rx_wr <= r_rx_wr + (AW+1)'(w_rx_accept);
            r_rx_rd <= r_rx_rd + (AW+1)'(w_rx_pop);
            if (w_rx_push && !w_rx_accept) r_overrun <= 1'b1;
            else if (clr_overrun)          r_overrun <= 1'b0;
        end
    end
endmodule
